// File: rtl/vram_blit.sv
// vram_blit: block fill / block copy engine for the linear 640-wide byte
// framebuffer (address = x + 640*y) that the VGA stage scans out.
//
// The CPU programs a job (fill with a constant byte, or copy from src to dst)
// and pulses start. The engine then requests one byte access per cycle on the
// shared VRAM port. An external arbiter decides when an access is taken
// (req=1 and grant=1). Until it is taken, everything holds.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   job request, only looked at while idle
//   mode     in   0 = fill, 1 = copy
//   src      in   copy source start address
//   dst      in   destination start address
//   len      in   byte count, 0..2^AW
//   value    in   fill byte
//   busy     out  job in progress
//   done     out  one-cycle completion pulse
//   req      out  memory access request
//   we       out  1 = write, 0 = read
//   addr     out  memory address
//   wdata    out  write data
//   grant    in   arbiter accepts the pending access this cycle
//   rdata    in   read data, valid one cycle after an accepted read
module vram_blit #(
  parameter int AW = 15,
  parameter int DW = 8,
  parameter int LW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] value,
  output logic          busy,
  output logic          done,
  output logic          req,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic          grant,
  input  logic [DW-1:0] rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    CP_RD  = 3'd2,
    CP_LAT = 3'd3,
    CP_WR  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] value_q, value_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          accept;

  // An access only counts when our registered request meets the grant.
  assign accept = req_q & grant;

  // Next-state logic. The port outputs are decoded from the *next* state and
  // pointers so that they come straight out of flops and never depend
  // combinationally on grant.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = FIN;
          end else begin
            src_d   = src;
            dst_d   = dst;
            cnt_d   = len;
            value_d = value;
            state_d = mode ? CP_RD : FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          dst_d = dst_q + AW'(1);
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = FIN;
          end
        end
      end

      CP_RD: begin
        if (accept) begin
          src_d   = src_q + AW'(1);
          state_d = CP_LAT;
        end
      end

      // Read data from the accepted read arrives this cycle; no grant needed.
      CP_LAT: begin
        hold_d  = rdata;
        state_d = CP_WR;
      end

      CP_WR: begin
        if (accept) begin
          dst_d   = dst_q + AW'(1);
          cnt_d   = cnt_q - LW'(1);
          state_d = (cnt_q == LW'(1)) ? FIN : CP_RD;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == FILL) || (state_d == CP_RD) ||
              (state_d == CP_LAT) || (state_d == CP_WR);
    done_d  = (state_d == FIN);
    req_d   = (state_d == FILL) || (state_d == CP_RD) || (state_d == CP_WR);
    we_d    = (state_d == FILL) || (state_d == CP_WR);

    addr_d  = '0;
    wdata_d = '0;
    if (state_d == CP_RD) begin
      addr_d = src_d;
    end else if ((state_d == FILL) || (state_d == CP_WR)) begin
      addr_d = dst_d;
    end
    if (state_d == FILL) begin
      wdata_d = value_d;
    end else if (state_d == CP_WR) begin
      wdata_d = hold_d;
    end
  end

  // All state and registered outputs. Reset aborts any job on the spot:
  // the request drops next cycle and no done pulse is produced.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign req   = req_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_vram_blit.sv
// tb_vram_blit: directed bench for vram_blit with a small byte memory model
// on the VRAM port. Expected values are hand-derived cycle by cycle.
module tb_vram_blit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [14:0] src;
  logic [14:0] dst;
  logic [15:0] len;
  logic [7:0]  value;
  logic        busy;
  logic        done;
  logic        req;
  logic        we;
  logic [14:0] addr;
  logic [7:0]  wdata;
  logic        grant;
  logic [7:0]  rdata;

  logic [7:0]  mem [0:32767];
  logic        preloadEn;
  logic [14:0] preloadAddr;
  logic [7:0]  preloadData;
  int          writeCount = 0;

  int checkCount = 0;
  int errorCount = 0;

  vram_blit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .grant   (grant),
    .rdata   (rdata)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // VRAM model: accepted writes land in mem, accepted reads return data one
  // cycle later. The preload path lets the bench seed bytes while idle.
  always @(posedge clock) begin
    if (preloadEn) begin
      mem[preloadAddr] <= preloadData;
    end else if (req && grant && we) begin
      mem[addr] <= wdata;
    end
    if (req && grant && !we) begin
      rdata <= mem[addr];
    end
  end

  // Counts accepted writes so jobs can be checked for skipped or extra bytes.
  always @(posedge clock) begin
    if (reset_n && req && grant && we) begin
      writeCount <= writeCount + 1;
    end
  end

  // Compares one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances to the next cycle; inputs may be changed and outputs sampled 1 ns after the edge.
  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Presents a job with start=1 for one cycle (cycle 0) and returns in cycle 1.
  task automatic applyStimulus(input logic m, input logic [14:0] s,
                               input logic [14:0] d, input logic [15:0] l,
                               input logic [7:0] v);
    start = 1'b1;
    mode  = m;
    src   = s;
    dst   = d;
    len   = l;
    value = v;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic preloadByte(input logic [14:0] a, input logic [7:0] d);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    stepCycle();
    preloadEn   = 1'b0;
  endtask

  initial begin
    logic [14:0] fillAddr [4];
    logic [7:0]  copyData [3];
    int          snap;
    int          k;
    int          ph;
    int          cyc;
    logic        seenReq;

    fillAddr[0] = 15'h7FFE;
    fillAddr[1] = 15'h7FFF;
    fillAddr[2] = 15'h0000;
    fillAddr[3] = 15'h0001;
    copyData[0] = 8'h11;
    copyData[1] = 8'h22;
    copyData[2] = 8'h33;

    reset_n     = 1'b0;
    start       = 1'b0;
    mode        = 1'b0;
    src         = '0;
    dst         = '0;
    len         = '0;
    value       = '0;
    grant       = 1'b1;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req", req, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_wdata", wdata, 0);
    reset_n = 1'b1;
    stepCycle();

    // Fill across the top of memory: addresses wrap and the job continues.
    $display("[TB] fill with address wrap");
    snap = writeCount;
    applyStimulus(1'b0, 15'h0000, 15'h7FFE, 16'd4, 8'hAA);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fill_req%0d", i), req, 1);
      checkOutput($sformatf("fill_we%0d", i), we, 1);
      checkOutput($sformatf("fill_addr%0d", i), addr, fillAddr[i]);
      checkOutput($sformatf("fill_wdata%0d", i), wdata, 8'hAA);
      checkOutput($sformatf("fill_busy%0d", i), busy, 1);
      checkOutput($sformatf("fill_done%0d", i), done, 0);
      stepCycle();
    end
    checkOutput("fill_fin_done", done, 1);
    checkOutput("fill_fin_busy", busy, 0);
    checkOutput("fill_fin_req", req, 0);
    checkOutput("fill_writes", writeCount - snap, 4);
    checkOutput("fill_mem7FFF", mem[15'h7FFF], 8'hAA);
    checkOutput("fill_mem0000", mem[15'h0000], 8'hAA);
    stepCycle();
    checkOutput("fill_done_pulse", done, 0);

    // Copy 3 bytes: read, latency, write per byte; done at cycle 10.
    $display("[TB] copy 0100 -> 0200");
    preloadByte(15'h0100, 8'h11);
    preloadByte(15'h0101, 8'h22);
    preloadByte(15'h0102, 8'h33);
    applyStimulus(1'b1, 15'h0100, 15'h0200, 16'd3, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      checkOutput($sformatf("cp_busy_c%0d", c), busy, 1);
      checkOutput($sformatf("cp_done_c%0d", c), done, 0);
      if (ph == 0) begin
        checkOutput($sformatf("cp_rdreq_c%0d", c), req, 1);
        checkOutput($sformatf("cp_rdwe_c%0d", c), we, 0);
        checkOutput($sformatf("cp_rdaddr_c%0d", c), addr, 15'h0100 + 15'(k));
      end else if (ph == 1) begin
        checkOutput($sformatf("cp_latreq_c%0d", c), req, 0);
      end else begin
        checkOutput($sformatf("cp_wrreq_c%0d", c), req, 1);
        checkOutput($sformatf("cp_wrwe_c%0d", c), we, 1);
        checkOutput($sformatf("cp_wraddr_c%0d", c), addr, 15'h0200 + 15'(k));
        checkOutput($sformatf("cp_wrdata_c%0d", c), wdata, copyData[k]);
      end
      stepCycle();
    end
    checkOutput("cp_done_c10", done, 1);
    checkOutput("cp_busy_c10", busy, 0);
    checkOutput("cp_mem0200", mem[15'h0200], 8'h11);
    checkOutput("cp_mem0201", mem[15'h0201], 8'h22);
    checkOutput("cp_mem0202", mem[15'h0202], 8'h33);
    stepCycle();

    // Grant stall: grant low in cycles 1-3, writes in 4 and 5, done at 6.
    $display("[TB] grant stall");
    snap  = writeCount;
    grant = 1'b0;
    applyStimulus(1'b0, 15'h0000, 15'h1000, 16'd2, 8'h5C);
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("stall_req_c%0d", c), req, 1);
      checkOutput($sformatf("stall_addr_c%0d", c), addr, 15'h1000);
      stepCycle();
    end
    grant = 1'b1;
    checkOutput("stall_addr_c4", addr, 15'h1000);
    checkOutput("stall_req_c4", req, 1);
    stepCycle();
    checkOutput("stall_addr_c5", addr, 15'h1001);
    checkOutput("stall_done_c5", done, 0);
    stepCycle();
    checkOutput("stall_done_c6", done, 1);
    checkOutput("stall_writes", writeCount - snap, 2);
    checkOutput("stall_mem1000", mem[15'h1000], 8'h5C);
    checkOutput("stall_mem1001", mem[15'h1001], 8'h5C);
    stepCycle();

    // Zero-length job: straight to done, never requests.
    $display("[TB] zero length");
    applyStimulus(1'b0, 15'h0000, 15'h0300, 16'd0, 8'h12);
    checkOutput("len0_done", done, 1);
    checkOutput("len0_busy", busy, 0);
    checkOutput("len0_req", req, 0);
    seenReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      seenReq = seenReq | req;
    end
    checkOutput("len0_noreq", seenReq, 0);

    // A second start mid-job is ignored.
    $display("[TB] start ignored while busy");
    snap = writeCount;
    applyStimulus(1'b0, 15'h0000, 15'h2000, 16'd4, 8'h77);
    checkOutput("ign_addr_c1", addr, 15'h2000);
    start = 1'b1;
    mode  = 1'b1;
    dst   = 15'h3000;
    len   = 16'd9;
    value = 8'h99;
    stepCycle();
    start = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      checkOutput($sformatf("ign_addr_c%0d", c), addr, 15'h2000 + 15'(c - 1));
      checkOutput($sformatf("ign_wdata_c%0d", c), wdata, 8'h77);
      checkOutput($sformatf("ign_we_c%0d", c), we, 1);
      stepCycle();
    end
    checkOutput("ign_done_c5", done, 1);
    stepCycle();
    checkOutput("ign_busy_c6", busy, 0);
    checkOutput("ign_writes", writeCount - snap, 4);

    // Reset during a copy, the cycle after the second write.
    $display("[TB] reset mid copy");
    snap = writeCount;
    applyStimulus(1'b1, 15'h0100, 15'h0400, 16'd3, 8'h00);
    for (int c = 1; c < 7; c++) begin
      stepCycle();
    end
    checkOutput("rmid_req_c7", req, 1);
    checkOutput("rmid_addr_c7", addr, 15'h0102);
    reset_n = 1'b0;
    stepCycle();
    reset_n = 1'b1;
    checkOutput("rmid_req_c8", req, 0);
    checkOutput("rmid_busy_c8", busy, 0);
    checkOutput("rmid_done_c8", done, 0);
    for (int c = 9; c <= 12; c++) begin
      stepCycle();
      checkOutput($sformatf("rmid_done_c%0d", c), done, 0);
      checkOutput($sformatf("rmid_req_c%0d", c), req, 0);
    end
    checkOutput("rmid_writes", writeCount - snap, 2);
    checkOutput("rmid_mem0400", mem[15'h0400], 8'h11);
    checkOutput("rmid_mem0401", mem[15'h0401], 8'h22);
    applyStimulus(1'b0, 15'h0000, 15'h0500, 16'd1, 8'h42);
    checkOutput("post_req", req, 1);
    checkOutput("post_addr", addr, 15'h0500);
    checkOutput("post_wdata", wdata, 8'h42);
    stepCycle();
    checkOutput("post_done", done, 1);
    checkOutput("post_mem0500", mem[15'h0500], 8'h42);
    stepCycle();

    // Full-memory fill: 32768 writes, done one cycle after the last write.
    $display("[TB] full memory fill");
    snap = writeCount;
    applyStimulus(1'b0, 15'h0000, 15'h1234, 16'd32768, 8'hE5);
    cyc = 1;
    while (!done && cyc < 33000) begin
      stepCycle();
      cyc++;
    end
    checkOutput("full_done_cycle", cyc, 32769);
    checkOutput("full_writes", writeCount - snap, 32768);
    checkOutput("full_mem1233", mem[15'h1233], 8'hE5);
    checkOutput("full_mem1234", mem[15'h1234], 8'hE5);
    checkOutput("full_mem0200", mem[15'h0200], 8'hE5);
    stepCycle();
    checkOutput("full_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
